// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants and state type for the 16-point radix-4 FFT stages
package fft16_pkg;

  localparam int FFT_N  = 16;
  localparam int RADIX  = 4;
  localparam int GROUPS = 4;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/radix4_ibfly.sv
// rtl/radix4_ibfly.sv - combinational radix-4 inverse butterfly (+j twiddle), sums at WIDTH+2
// STAGE1_IFFT_SCALE_EN selects floor(sum/4) instead of a plain low-WIDTH wrap.
module radix4_ibfly #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] xr0,
  input  logic signed [WIDTH-1:0] xi0,
  input  logic signed [WIDTH-1:0] xr1,
  input  logic signed [WIDTH-1:0] xi1,
  input  logic signed [WIDTH-1:0] xr2,
  input  logic signed [WIDTH-1:0] xi2,
  input  logic signed [WIDTH-1:0] xr3,
  input  logic signed [WIDTH-1:0] xi3,
  output logic signed [WIDTH-1:0] yr0,
  output logic signed [WIDTH-1:0] yi0,
  output logic signed [WIDTH-1:0] yr1,
  output logic signed [WIDTH-1:0] yi1,
  output logic signed [WIDTH-1:0] yr2,
  output logic signed [WIDTH-1:0] yi2,
  output logic signed [WIDTH-1:0] yr3,
  output logic signed [WIDTH-1:0] yi3
);

  logic signed [WIDTH+1:0] ar0, ai0, ar1, ai1, ar2, ai2, ar3, ai3;
  logic signed [WIDTH+1:0] sr0, si0, sr1, si1, sr2, si2, sr3, si3;

  function automatic logic signed [WIDTH-1:0] fit(input logic signed [WIDTH+1:0] s);
`ifdef STAGE1_IFFT_SCALE_EN
    return WIDTH'(s >>> 2);
`else
    return WIDTH'(s);
`endif
  endfunction

  always_comb begin
    ar0 = (WIDTH+2)'(xr0);
    ai0 = (WIDTH+2)'(xi0);
    ar1 = (WIDTH+2)'(xr1);
    ai1 = (WIDTH+2)'(xi1);
    ar2 = (WIDTH+2)'(xr2);
    ai2 = (WIDTH+2)'(xi2);
    ar3 = (WIDTH+2)'(xr3);
    ai3 = (WIDTH+2)'(xi3);
    // Four full-scale terms cannot exceed 2^(WIDTH+1), so WIDTH+2 never overflows.
    sr0 = ar0 + ar1 + ar2 + ar3;
    si0 = ai0 + ai1 + ai2 + ai3;
    sr1 = ar0 - ar2 - ai1 + ai3;
    si1 = ai0 - ai2 + ar1 - ar3;
    sr2 = ar0 - ar1 + ar2 - ar3;
    si2 = ai0 - ai1 + ai2 - ai3;
    sr3 = ar0 - ar2 + ai1 - ai3;
    si3 = ai0 - ai2 - ar1 + ar3;
  end

  assign yr0 = fit(sr0);
  assign yi0 = fit(si0);
  assign yr1 = fit(sr1);
  assign yi1 = fit(si1);
  assign yr2 = fit(sr2);
  assign yi2 = fit(si2);
  assign yr3 = fit(sr3);
  assign yi3 = fit(si3);

endmodule

// File: rtl/stage1_ibutterfly_seq.sv
// rtl/stage1_ibutterfly_seq.sv - serial 16-point radix-4 stage-1 inverse butterfly (load, compute, unload)
// Optional STAGE1_IFFT_SCALE_EN enables 1/4 per-stage scaling inside radix4_ibfly.
module stage1_ibutterfly_seq
  import fft16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              g_q, g_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_re_q, out_re_d;
  logic signed [WIDTH-1:0] out_im_q, out_im_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;

  logic signed [WIDTH-1:0] xbuf_re_q [FFT_N];
  logic signed [WIDTH-1:0] xbuf_im_q [FFT_N];
  logic signed [WIDTH-1:0] ybuf_re_q [FFT_N];
  logic signed [WIDTH-1:0] ybuf_im_q [FFT_N];

  logic                    x_we, y_we;
  logic [IDX_W-1:0]        nxt_idx;
  logic signed [WIDTH-1:0] bf_yr [RADIX];
  logic signed [WIDTH-1:0] bf_yi [RADIX];

  // Group g reads x[g + 4m]: the buffer index is simply {m, g}.
  radix4_ibfly #(.WIDTH(WIDTH)) u_bfly (
    .xr0(xbuf_re_q[{2'd0, g_q}]), .xi0(xbuf_im_q[{2'd0, g_q}]),
    .xr1(xbuf_re_q[{2'd1, g_q}]), .xi1(xbuf_im_q[{2'd1, g_q}]),
    .xr2(xbuf_re_q[{2'd2, g_q}]), .xi2(xbuf_im_q[{2'd2, g_q}]),
    .xr3(xbuf_re_q[{2'd3, g_q}]), .xi3(xbuf_im_q[{2'd3, g_q}]),
    .yr0(bf_yr[0]), .yi0(bf_yi[0]),
    .yr1(bf_yr[1]), .yi1(bf_yi[1]),
    .yr2(bf_yr[2]), .yi2(bf_yi[2]),
    .yr3(bf_yr[3]), .yi3(bf_yi[3])
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    g_d         = g_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    x_we        = 1'b0;
    y_we        = 1'b0;
    nxt_idx     = out_idx_q + 1'b1;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          x_we = 1'b1;
          if (cnt_q == IDX_W'(FFT_N - 1)) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        y_we = 1'b1;
        g_d  = g_q + 1'b1;
        if (g_q == 2'(GROUPS - 1)) state_d = UNLOAD;
      end
      UNLOAD: begin
        // First UNLOAD cycle primes the registered output from ybuf[0].
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_re_d    = ybuf_re_q[IDX_W'(0)];
          out_im_d    = ybuf_im_q[IDX_W'(0)];
          out_last_d  = 1'b0;
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d     = LOAD;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
          end else begin
            out_idx_d  = nxt_idx;
            out_re_d   = ybuf_re_q[nxt_idx];
            out_im_d   = ybuf_im_q[nxt_idx];
            out_last_d = (nxt_idx == IDX_W'(FFT_N - 1));
          end
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      g_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (x_we) begin
      xbuf_re_q[cnt_q] <= in_re;
      xbuf_im_q[cnt_q] <= in_im;
    end
    if (y_we) begin
      for (int k = 0; k < RADIX; k++) begin
        ybuf_re_q[{g_q, 2'(k)}] <= bf_yr[k];
        ybuf_im_q[{g_q, 2'(k)}] <= bf_yi[k];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_stage1_ibutterfly_seq.sv
// tb/tb_stage1_ibutterfly_seq.sv - scoreboard bench for stage1_ibutterfly_seq against a j^(mk) DFT-4 model
module tb_stage1_ibutterfly_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [W-1:0] out_re, out_im;
  logic [3:0] out_idx;
  logic out_last, busy;

  always #5 clk = ~clk;

  stage1_ibutterfly_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] exp_re_q[$];
  logic signed [W-1:0] exp_im_q[$];
  int mon_idx = 0;
  int n_out = 0;
  int n_expected = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit lat_armed = 0;
  int bp_mode = 0;
  int stall_cnt = 0;
  bit bp_done = 0;
  bit junk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic signed [W-1:0] fix(input int v);
    int t;
    t = v;
`ifdef STAGE1_IFFT_SCALE_EN
    t = t >>> 2;
`endif
    return W'(t);
  endfunction

  // y[4g+k] = sum_m x[g+4m] * j^(m*k)
  task automatic push_expected(input logic signed [W-1:0] xr[16], input logic signed [W-1:0] xi[16]);
    for (int idx = 0; idx < 16; idx++) begin
      int g, k, sr, si;
      g = idx / 4;
      k = idx % 4;
      sr = 0;
      si = 0;
      for (int m = 0; m < 4; m++) begin
        int ar, ai;
        ar = int'(xr[g + 4 * m]);
        ai = int'(xi[g + 4 * m]);
        case ((m * k) % 4)
          0: begin sr += ar; si += ai; end
          1: begin sr -= ai; si += ar; end
          2: begin sr -= ar; si -= ai; end
          default: begin sr += ai; si -= ar; end
        endcase
      end
      exp_re_q.push_back(fix(sr));
      exp_im_q.push_back(fix(si));
      n_expected++;
    end
  endtask

  // Output driver for out_ready: 0 always ready, 1 random, 2 three-cycle stall at idx 5.
  always begin
    @(posedge clk);
    #1;
    case (bp_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else if (out_valid && out_idx == 4'd5 && !bp_done) begin
          out_ready = 1'b0;
          stall_cnt = 2;
          bp_done = 1;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  logic stall_seen = 0;
  logic signed [W-1:0] s_re, s_im;
  logic [3:0] s_idx;
  logic s_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_re", int'(out_re), int'(s_re));
        chk("hold_im", int'(out_im), int'(s_im));
        chk("hold_idx", int'(out_idx), int'(s_idx));
        chk("hold_last", int'(out_last), int'(s_last));
      end
      stall_seen = 0;
      if (out_valid) begin
        if (lat_armed) begin
          chk("latency", cyc - last_acc_cyc, 5);
          lat_armed = 0;
        end
        if (out_ready) begin
          if (exp_re_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got idx %0d expected no output", out_idx);
          end else begin
            logic signed [W-1:0] er, ei;
            er = exp_re_q.pop_front();
            ei = exp_im_q.pop_front();
            chk("out_re", int'(out_re), int'(er));
            chk("out_im", int'(out_im), int'(ei));
            chk("out_idx", int'(out_idx), mon_idx);
            chk("out_last", int'(out_last), int'(mon_idx == 15));
            chk("in_ready_unload", int'(in_ready), 0);
            chk("busy_unload", int'(busy), 1);
            mon_idx = (mon_idx + 1) % 16;
            n_out++;
          end
        end else begin
          stall_seen = 1;
          s_re = out_re;
          s_im = out_im;
          s_idx = out_idx;
          s_last = out_last;
        end
      end
    end
  end

  task automatic send_frame(input logic signed [W-1:0] xr[16], input logic signed [W-1:0] xi[16],
                            input bit throttle);
    push_expected(xr, xi);
    for (int i = 0; i < 16; i++) begin
      int t;
      if (throttle) begin
        in_valid = 1'b0;
        in_re = W'($urandom);
        in_im = W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_re = xr[i];
      in_im = xi[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready || t > 200) break;
        t++;
      end
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 at sample %0d", i);
      end
      if (i == 15) begin
        last_acc_cyc = cyc + 1;
        lat_armed = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_re_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      in_valid = junk & busy;
      if (junk) begin
        in_re = W'($urandom);
        in_im = W'($urandom);
      end
      t++;
    end
    in_valid = 1'b0;
    if (exp_re_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_re_q.size());
      n_expected -= exp_re_q.size();
      exp_re_q.delete();
      exp_im_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic signed [W-1:0] xr[16], xi[16], rr[16], ri[16];

  initial begin
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Twiddle sign: single impulse at x[4].
    for (int i = 0; i < 16; i++) begin xr[i] = '0; xi[i] = '0; end
    xi[4] = 16'sd100;
    send_frame(xr, xi, 0);
    wait_done();

    // Ramp
    for (int i = 0; i < 16; i++) begin xr[i] = W'(i); xi[i] = W'(-i); end
    send_frame(xr, xi, 0);
    wait_done();

    // Overflow on y0 real
    for (int i = 0; i < 16; i++) begin xr[i] = '0; xi[i] = '0; end
    xr[0] = 16'sd16384; xr[4] = 16'sd16384; xr[8] = 16'sd16384; xr[12] = 16'sd16384;
    send_frame(xr, xi, 0);
    wait_done();

    // Random frames with random backpressure, including full-scale corners.
    bp_mode = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        if (f == 2) begin
          xr[i] = (i % 2 == 0) ? -16'sd32768 : 16'sd32767;
          xi[i] = (i % 3 == 0) ? 16'sd32767 : -16'sd32768;
        end else begin
          xr[i] = W'($urandom);
          xi[i] = W'($urandom);
        end
      end
      send_frame(xr, xi, 0);
      wait_done();
    end

    // Backpressure stall at idx 5, with junk in_valid while busy.
    bp_mode = 2;
    junk = 1;
    for (int i = 0; i < 16; i++) begin xr[i] = W'($urandom); xi[i] = W'($urandom); end
    send_frame(xr, xi, 0);
    wait_done();
    junk = 0;
    bp_mode = 0;
    chk("bp_stall_happened", int'(bp_done), 1);

    // Reset mid-UNLOAD at idx 9.
    for (int i = 0; i < 16; i++) begin xr[i] = W'($urandom); xi[i] = W'($urandom); end
    send_frame(xr, xi, 0);
    begin
      int t;
      t = 0;
      while (!(out_valid && out_idx == 4'd9) && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("reach_idx9", int'(out_valid && out_idx == 4'd9), 1);
    end
    rst = 1'b1;
    n_expected -= exp_re_q.size();
    exp_re_q.delete();
    exp_im_q.delete();
    mon_idx = 0;
    lat_armed = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_idx", int'(out_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh frame, then the same random data unthrottled and throttled.
    for (int i = 0; i < 16; i++) begin xr[i] = W'(i); xi[i] = W'(-i); end
    send_frame(xr, xi, 0);
    wait_done();
    for (int i = 0; i < 16; i++) begin rr[i] = W'($urandom); ri[i] = W'($urandom); end
    send_frame(rr, ri, 0);
    wait_done();
    send_frame(rr, ri, 1);
    wait_done();

    chk("total_outputs", n_out, n_expected);
    chk("scoreboard_empty", exp_re_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
